// File: rtl/gpu_cmd_pkg.sv
// gpu_cmd_pkg: shared constants, the packer state type and the
// three-word-to-instruction packing function for the GPU command path.
package gpu_cmd_pkg;

  localparam int INSTWIDTH = 82;

  localparam logic [31:0] START_WORD = 32'hF00BF00B;
  localparam logic [31:0] STOP_WORD  = 32'hDEADF00B;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    W0   = 2'd1,
    W1   = 2'd2,
    W2   = 2'd3
  } pack_state_t;

  // Low 14 bits of the third word carry no instruction content.
  function automatic logic [INSTWIDTH-1:0] pack_inst(input logic [31:0] w0,
                                                     input logic [31:0] w1,
                                                     input logic [31:0] w2);
    return {w0, w1, w2[31:14]};
  endfunction

endpackage

// File: rtl/gpu_inst_fifo.sv
// gpu_inst_fifo: generic show-ahead synchronous FIFO.
// Ports:
//   clk, reset_n  - clock, async active-low reset
//   clr           - synchronous flush, wins over push/pop
//   push, din     - write request and data
//   pop           - advance the head (ignored when empty)
//   dout          - head entry, forced to 0 while empty
//   empty, full   - status; full is count==DEPTH
//   count         - entries held, 0..DEPTH
// A push while full is accepted only when a pop happens in the same cycle.
module gpu_inst_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 82
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     clr,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      // Power-of-two depth: pointers wrap naturally.
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: dout is masked while empty.
  always_ff @(posedge clk) begin
    if (do_push && !clr) mem_q[wr_ptr_q] <= din;
  end

  assign dout  = empty ? '0 : mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/gpu_cmd_packer.sv
// gpu_cmd_packer: frames host command words between START/STOP markers,
// packs every three words into an 82-bit instruction and buffers them in a
// show-ahead FIFO for the GPU core.
// Ports:
//   clk, reset_n         - clock, async active-low reset
//   soft_clr             - synchronous flush of FIFO, FSM and sticky flags
//   wr_valid, wr_data    - command word strobe and value
//   fifo_rd              - pop head instruction
//   fifo_data/empty/count- show-ahead FIFO view
//   in_frame, frame_done - framing status / STOP-accepted pulse
//   overflow, frame_err  - sticky error flags
// Build option: GPU_CMD_FRAMING_EN enables START/STOP framing. Without it
// the packer free-runs from W0 and every three words form an instruction.
module gpu_cmd_packer #(
  parameter int DEPTH     = 16,
  parameter int DATAWIDTH = 32,
  parameter int INSTWIDTH = 82
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     soft_clr,
  input  logic                     wr_valid,
  input  logic [DATAWIDTH-1:0]     wr_data,
  input  logic                     fifo_rd,
  output logic [INSTWIDTH-1:0]     fifo_data,
  output logic                     fifo_empty,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     in_frame,
  output logic                     frame_done,
  output logic                     overflow,
  output logic                     frame_err
);

  import gpu_cmd_pkg::*;

`ifdef GPU_CMD_FRAMING_EN
  localparam pack_state_t RST_STATE = IDLE;
`else
  localparam pack_state_t RST_STATE = W0;
`endif

  pack_state_t            state_q, state_d;
  logic [DATAWIDTH-1:0]   w0_q, w0_d;
  logic [DATAWIDTH-1:0]   w1_q, w1_d;
  logic                   overflow_q, overflow_d;
  logic                   push;
  logic                   fifo_full;

  // ---- state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= RST_STATE;
    else          state_q <= state_d;
  end

  // ---- next state
  always_comb begin
    state_d = state_q;
    if (soft_clr) begin
      state_d = RST_STATE;
    end else if (wr_valid) begin
      case (state_q)
`ifdef GPU_CMD_FRAMING_EN
        IDLE: if (wr_data == START_WORD) state_d = W0;
        W0: begin
          if (wr_data == STOP_WORD)       state_d = IDLE;
          else if (wr_data == START_WORD) state_d = W0;
          else                            state_d = W1;
        end
`else
        IDLE: state_d = W0;
        W0:   state_d = W1;
`endif
        W1:      state_d = W2;
        W2:      state_d = W0;
        default: state_d = RST_STATE;
      endcase
    end
  end

  // ---- outputs: staging, push, flag events
`ifdef GPU_CMD_FRAMING_EN
  logic stop_acc, err_set;
  logic frame_done_q, frame_done_d;
  logic frame_err_q, frame_err_d;
`endif

  always_comb begin
    w0_d = w0_q;
    w1_d = w1_q;
    push = 1'b0;
`ifdef GPU_CMD_FRAMING_EN
    stop_acc = 1'b0;
    err_set  = 1'b0;
`endif
    if (!soft_clr && wr_valid) begin
      case (state_q)
`ifdef GPU_CMD_FRAMING_EN
        IDLE: if (wr_data != START_WORD) err_set = 1'b1;
        W0: begin
          if (wr_data == STOP_WORD)       stop_acc = 1'b1;
          else if (wr_data == START_WORD) err_set  = 1'b1;
          else                            w0_d     = wr_data;
        end
`else
        W0: w0_d = wr_data;
`endif
        // Markers are plain data once a word has been staged.
        W1:      w1_d = wr_data;
        W2:      push = 1'b1;
        default: ;
      endcase
    end
  end

  // A full FIFO still takes the push if the core pops in the same cycle.
  assign overflow_d = soft_clr ? 1'b0
                    : (overflow_q | (push && fifo_full && !fifo_rd));

`ifdef GPU_CMD_FRAMING_EN
  assign frame_done_d = stop_acc;
  assign frame_err_d  = soft_clr ? 1'b0 : (frame_err_q | err_set);
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      w0_q       <= '0;
      w1_q       <= '0;
      overflow_q <= 1'b0;
    end else begin
      w0_q       <= soft_clr ? '0 : w0_d;
      w1_q       <= soft_clr ? '0 : w1_d;
      overflow_q <= overflow_d;
    end
  end

`ifdef GPU_CMD_FRAMING_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_done_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      frame_done_q <= frame_done_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign in_frame   = (state_q != IDLE);
  assign frame_done = frame_done_q;
  assign frame_err  = frame_err_q;
`else
  assign in_frame   = 1'b1;
  assign frame_done = 1'b0;
  assign frame_err  = 1'b0;
`endif

  assign overflow = overflow_q;

  gpu_inst_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (INSTWIDTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (soft_clr),
    .push    (push),
    .pop     (fifo_rd),
    .din     (pack_inst(w0_q, w1_q, wr_data)),
    .dout    (fifo_data),
    .empty   (fifo_empty),
    .full    (fifo_full),
    .count   (fifo_count)
  );

endmodule

// File: tb/tb_gpu_cmd_packer.sv
// tb_gpu_cmd_packer: directed, table-driven bench for gpu_cmd_packer.
// Works in both builds (GPU_CMD_FRAMING_EN defined or not).
module tb_gpu_cmd_packer;

  localparam int DEPTH = 16;
  localparam logic [31:0] START_W = 32'hF00BF00B;
  localparam logic [31:0] STOP_W  = 32'hDEADF00B;
`ifdef GPU_CMD_FRAMING_EN
  localparam logic FRAMED = 1'b1;
`else
  localparam logic FRAMED = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n, soft_clr, wr_valid, fifo_rd;
  logic [31:0] wr_data;
  logic [81:0] fifo_data;
  logic        fifo_empty, in_frame, frame_done, overflow, frame_err;
  logic [4:0]  fifo_count;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  gpu_cmd_packer #(.DEPTH(DEPTH), .DATAWIDTH(32), .INSTWIDTH(82)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .soft_clr   (soft_clr),
    .wr_valid   (wr_valid),
    .wr_data    (wr_data),
    .fifo_rd    (fifo_rd),
    .fifo_data  (fifo_data),
    .fifo_empty (fifo_empty),
    .fifo_count (fifo_count),
    .in_frame   (in_frame),
    .frame_done (frame_done),
    .overflow   (overflow),
    .frame_err  (frame_err)
  );

  typedef struct {
    logic [31:0] w0, w1, w2;
    logic [81:0] exp;
  } vec_t;

  vec_t tbl [4];

  task automatic chk(input string name, input logic [81:0] act, input logic [81:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // All tasks start and end 1 time unit after a rising edge.
  task automatic send(input logic [31:0] w, input logic rd = 1'b0);
    wr_data = w; wr_valid = 1'b1; fifo_rd = rd;
    @(posedge clk); #1;
    wr_valid = 1'b0; fifo_rd = 1'b0;
  endtask

  task automatic pop();
    fifo_rd = 1'b1;
    @(posedge clk); #1;
    fifo_rd = 1'b0;
  endtask

  task automatic sclr();
    soft_clr = 1'b1;
    @(posedge clk); #1;
    soft_clr = 1'b0;
  endtask

  task automatic open_frame();
    if (FRAMED) send(START_W);
  endtask

  // Overflow/drain pattern: w2 carries i in its kept upper 18 bits.
  function automatic logic [31:0] pw0(input int i); return 32'h100 + 32'(i); endfunction
  function automatic logic [31:0] pw1(input int i); return ~32'(i); endfunction
  function automatic logic [31:0] pw2(input int i); return 32'(i) << 14; endfunction
  function automatic logic [81:0] pexp(input int i);
    return {pw0(i), pw1(i), 18'(i)};
  endfunction

  task automatic send_inst(input int i, input logic rd_last = 1'b0);
    send(pw0(i));
    send(pw1(i));
    send(pw2(i), rd_last);
  endtask

  initial begin
    tbl[0] = '{32'h11111111, 32'h22222222, 32'hABCDC000,
               {32'h11111111, 32'h22222222, 18'h2AF37}};
    tbl[1] = '{32'h00000000, 32'h00000000, 32'h00003FFF, 82'h0};
    tbl[2] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFC000,
               {32'hFFFFFFFF, 32'hFFFFFFFF, 18'h3FFFF}};
    tbl[3] = '{32'h12345678, 32'h9ABCDEF0, 32'h00014000,
               {32'h12345678, 32'h9ABCDEF0, 18'h00005}};

    reset_n = 1'b0; soft_clr = 1'b0; wr_valid = 1'b0; fifo_rd = 1'b0; wr_data = '0;
    #12;
    chk("rst_empty", 82'(fifo_empty), 82'd1);
    chk("rst_data", fifo_data, 82'd0);
    chk("rst_count", 82'(fifo_count), 82'd0);
    chk("rst_in_frame", 82'(in_frame), FRAMED ? 82'd0 : 82'd1);
    chk("rst_done", 82'(frame_done), 82'd0);
    chk("rst_ovf", 82'(overflow), 82'd0);
    chk("rst_err", 82'(frame_err), 82'd0);
    @(negedge clk); reset_n = 1'b1;
    @(posedge clk); #1;

    // Pop on empty is ignored.
    pop();
    chk("pop_empty_count", 82'(fifo_count), 82'd0);
    chk("pop_empty_flag", 82'(fifo_empty), 82'd1);

    // Table: one (framed) instruction per entry.
    for (int i = 0; i < 4; i++) begin
      open_frame();
      send(tbl[i].w0); send(tbl[i].w1); send(tbl[i].w2);
      chk($sformatf("tbl%0d_data", i), fifo_data, tbl[i].exp);
      chk($sformatf("tbl%0d_count", i), 82'(fifo_count), 82'd1);
      if (FRAMED) begin
        send(STOP_W);
        chk($sformatf("tbl%0d_done", i), 82'(frame_done), 82'd1);
        chk($sformatf("tbl%0d_err", i), 82'(frame_err), 82'd0);
        chk($sformatf("tbl%0d_idle", i), 82'(in_frame), 82'd0);
        @(posedge clk); #1;
        chk($sformatf("tbl%0d_done_pulse", i), 82'(frame_done), 82'd0);
      end
      pop();
      chk($sformatf("tbl%0d_drained", i), 82'(fifo_empty), 82'd1);
    end

    if (FRAMED) begin
      // Data word while idle.
      send(32'h12345678);
      chk("idle_data_err", 82'(frame_err), 82'd1);
      chk("idle_data_nopush", 82'(fifo_count), 82'd0);
      chk("idle_data_state", 82'(in_frame), 82'd0);
      sclr();
      chk("sclr_err", 82'(frame_err), 82'd0);

      // START in W0 resyncs with an error; STOP then closes cleanly.
      send(START_W); send(START_W);
      chk("resync_err", 82'(frame_err), 82'd1);
      chk("resync_in_frame", 82'(in_frame), 82'd1);
      send(STOP_W);
      chk("resync_stop_idle", 82'(in_frame), 82'd0);
      chk("resync_stop_done", 82'(frame_done), 82'd1);
      chk("resync_count", 82'(fifo_count), 82'd0);
      sclr();

      // STOP after a staged w0 is data, not a terminator.
      send(START_W); send(32'h00000055); send(STOP_W);
      chk("w1_stop_in_frame", 82'(in_frame), 82'd1);
      chk("w1_stop_nodone", 82'(frame_done), 82'd0);
      chk("w1_stop_noerr", 82'(frame_err), 82'd0);
      chk("w1_stop_count", 82'(fifo_count), 82'd0);
      send(32'h0);
      chk("w1_stop_data", fifo_data, {32'h00000055, 32'hDEADF00B, 18'h0});
      sclr();

      // Marker as data; FSM ends in W0 so the next STOP closes the frame.
      send(START_W); send(32'h1); send(STOP_W); send(32'hFFFFFFFF);
      chk("marker_data", fifo_data, {32'h00000001, 32'hDEADF00B, 18'h3FFFF});
      chk("marker_count", 82'(fifo_count), 82'd1);
      send(STOP_W);
      chk("marker_w0_stop", 82'(frame_done), 82'd1);
      chk("marker_idle", 82'(in_frame), 82'd0);
      sclr();
    end else begin
      // Without framing, markers are ordinary words.
      send(START_W); send(STOP_W); send(32'h0);
      chk("nf_marker_data", fifo_data, {32'hF00BF00B, 32'hDEADF00B, 18'h0});
      chk("nf_in_frame", 82'(in_frame), 82'd1);
      chk("nf_done", 82'(frame_done), 82'd0);
      chk("nf_err", 82'(frame_err), 82'd0);
      sclr();
    end

    // Overflow: 17 instructions, no reads.
    open_frame();
    for (int i = 0; i < 17; i++) begin
      send_inst(i);
      if (i == 15) begin
        chk("fill16_count", 82'(fifo_count), 82'd16);
        chk("fill16_noovf", 82'(overflow), 82'd0);
      end
    end
    chk("ovf_count", 82'(fifo_count), 82'd16);
    chk("ovf_flag", 82'(overflow), 82'd1);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("drain%0d", i), fifo_data, pexp(i));
      pop();
    end
    chk("drain_empty", 82'(fifo_empty), 82'd1);
    chk("drain_data0", fifo_data, 82'd0);
    chk("ovf_sticky", 82'(overflow), 82'd1);
    sclr();
    chk("ovf_cleared", 82'(overflow), 82'd0);

    // Full boundary: push with a same-cycle pop is accepted.
    open_frame();
    for (int i = 0; i < 16; i++) send_inst(i);
    send_inst(16, 1'b1);
    chk("full_pp_count", 82'(fifo_count), 82'd16);
    chk("full_pp_noovf", 82'(overflow), 82'd0);
    chk("full_pp_head", fifo_data, pexp(1));
    for (int i = 0; i < 15; i++) pop();
    chk("full_pp_tail", fifo_data, pexp(16));
    sclr();

    // soft_clr wins over a simultaneous write and read.
    open_frame();
    send_inst(3);
    send(32'hCAFEF00D);
    soft_clr = 1'b1; wr_valid = 1'b1; wr_data = START_W; fifo_rd = 1'b1;
    @(posedge clk); #1;
    soft_clr = 1'b0; wr_valid = 1'b0; fifo_rd = 1'b0;
    chk("sclr_wr_empty", 82'(fifo_empty), 82'd1);
    chk("sclr_wr_count", 82'(fifo_count), 82'd0);
    chk("sclr_wr_in_frame", 82'(in_frame), FRAMED ? 82'd0 : 82'd1);
    if (FRAMED) begin
      send(32'h00000001);
      chk("sclr_wr_idle", 82'(frame_err), 82'd1);
      sclr();
    end else begin
      send(32'hAAAAAAAA); send(32'h55555555); send(32'hFFFFFFFF);
      chk("sclr_wr_w0", fifo_data, {32'hAAAAAAAA, 32'h55555555, 18'h3FFFF});
      sclr();
    end

    // Asynchronous reset while in W1 with an instruction queued.
    open_frame();
    send_inst(5);
    send(32'h0BADBEEF);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_empty", 82'(fifo_empty), 82'd1);
    chk("arst_data", fifo_data, 82'd0);
    chk("arst_count", 82'(fifo_count), 82'd0);
    chk("arst_in_frame", 82'(in_frame), FRAMED ? 82'd0 : 82'd1);
    chk("arst_ovf", 82'(overflow), 82'd0);
    @(negedge clk); reset_n = 1'b1;
    @(posedge clk); #1;
    open_frame();
    send(32'h01020304); send(32'h05060708); send(32'h090A0000);
    chk("arst_after_data", fifo_data, {32'h01020304, 32'h05060708, 18'h02428});
    chk("arst_after_count", 82'(fifo_count), 82'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
